// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-cell based counter slice.
//   jk_cmd_e     : the four JK storage commands, encoded as {j,k}.
//   JK_MAX_WIDTH : widest counter the excitation logic is meant for.
// ---------------------------------------------------------------------------
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  localparam int JK_MAX_WIDTH = 16;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One JK storage bit.
// Ports:
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset, q forced to 0
//   j, k    in  command: 00 hold, 01 clear, 10 set, 11 toggle
//   q       out stored bit
//   q_b     out inverted stored bit
// ---------------------------------------------------------------------------
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_b
);

  logic r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 1'b0;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q   = r_q;
  assign q_b = ~r_q;

endmodule : jk_cell

// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter
// WIDTH-bit synchronous up/down counter whose state lives in WIDTH jk_cell
// instances. This level only turns clr/load/en/up into per-bit {j,k} pairs
// and derives the terminal-count / cascade outputs.
//
// Parameters:
//   WIDTH    counter width, 2..JK_MAX_WIDTH
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, count forced to 0
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load of load_val
//   load_val in   value loaded when load=1
//   en       in   count enable
//   up       in   1 = increment, 0 = decrement
//   count    out  counter state, straight from the cell outputs
//   tc       out  terminal count (all-ones going up, zero going down)
//   co       out  cascade enable = tc & en
//
// Build option: JK_COUNTER_SATURATE_EN
//   defined   : counting stops at the terminal value instead of wrapping
//   undefined : modulo 2^WIDTH wrap
// ---------------------------------------------------------------------------
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             co
);

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_q_b;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tc;
  logic             w_up_run;
  logic             w_dn_run;

  // Terminal count uses the cells' inverted outputs for the all-zero test.
  assign w_tc = up ? (&w_count) : (&w_q_b);

  // Toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  // The running AND is built one bit at a time so each stage reuses the last.
  always_comb begin
    w_t      = '0;
    w_t[0]   = 1'b1;
    w_up_run = 1'b1;
    w_dn_run = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_run = w_up_run & w_count[i-1];
      w_dn_run = w_dn_run & w_q_b[i-1];
      w_t[i]   = up ? w_up_run : w_dn_run;
    end
`ifdef JK_COUNTER_SATURATE_EN
    // At the limit in the current direction, suppress every toggle.
    if (w_tc) begin
      w_t = '0;
    end
`endif
  end

  // Command priority: clr > load > en > hold.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (clr) begin
      w_k = '1;
    end else if (load) begin
      w_j = load_val;
      w_k = ~load_val;
    end else if (en) begin
      w_j = w_t;
      w_k = w_t;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .j       (w_j[g]),
      .k       (w_k[g]),
      .q       (w_count[g]),
      .q_b     (w_q_b[g])
    );
  end

  assign count = w_count;
  assign tc    = w_tc;
  assign co    = w_tc & en;

endmodule : jk_updown_counter
